serial_adder: RTL and testbench

Bit-serial N-bit adder with ready/valid handshakes on both sides, processing one bit per clock LSB-first through a single registered full-adder cell. It is the inverse arithmetic path to the team's subtractor blocks: it rebuilds a minuend from difference and subtrahend. It also serves as the area-minimal adder for multi-cycle datapaths.

---
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, one full-adder step per clock LSB-first; result WIDTH cycles after accept.
// Upstream stalls while busy (in_ready only in IDLE); the result is held in DONE until out_ready.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             fa_s, fa_c;

  assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d     = a;
          b_sh_d     = b;
          sum_sh_d   = '0;
          carry_d    = 1'b0;
          cnt_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        carry_d            = fa_c;
        sum_sh_d           = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]  = fa_s;
        a_sh_d             = a_sh_q >> 1;
        b_sh_d             = b_sh_q >> 1;
        cnt_d              = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // Handshake flags are flopped alongside the state so both ports stay glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_sh_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 1 and 32 against an arithmetic reference.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, cout1;
  logic [0:0] a1, b1, sum1;
  logic        in_valid32, in_ready32, out_valid32, out_ready32, cout32;
  logic [31:0] a32, b32, sum32;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8));
  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1));
  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32), .cout(cout32));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input string nm);
    logic [8:0] exp;
    int lat;
    exp = {1'b0, x} + {1'b0, y};
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b want 1", nm, in_ready8);
    end
    a8 = x; b8 = y; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    checks++;
    if (in_ready8 !== 1'b0) begin
      errors++; $display("FAIL %s ready_busy: got %b want 0", nm, in_ready8);
    end
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 64) begin tick(); lat++; end
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL %s latency: got %0d want 8", nm, lat);
    end
    checks++;
    if ({cout8, sum8} !== exp) begin
      errors++; $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h", nm, cout8, sum8, exp[8], exp[7:0]);
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++; $display("FAIL %s return_idle: got ready=%b valid=%b want 1/0", nm, in_ready8, out_valid8);
    end
  endtask

  task automatic run1(input logic x, input logic y, input string nm);
    logic [1:0] exp;
    int lat;
    exp = {1'b0, x} + {1'b0, y};
    a1 = x; b1 = y; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (out_valid1 !== 1'b1 && lat < 64) begin tick(); lat++; end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL %s latency: got %0d want 1", nm, lat);
    end
    checks++;
    if ({cout1, sum1} !== exp) begin
      errors++; $display("FAIL %s result: got cout=%b sum=%b want cout=%b sum=%b", nm, cout1, sum1, exp[1], exp[0]);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] y, input string nm);
    logic [32:0] exp;
    int lat;
    exp = {1'b0, x} + {1'b0, y};
    a32 = x; b32 = y; in_valid32 = 1'b1;
    tick();
    in_valid32 = 1'b0;
    lat = 0;
    while (out_valid32 !== 1'b1 && lat < 128) begin tick(); lat++; end
    checks++;
    if (lat !== 32) begin
      errors++; $display("FAIL %s latency: got %0d want 32", nm, lat);
    end
    checks++;
    if ({cout32, sum32} !== exp) begin
      errors++; $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h", nm, cout32, sum32, exp[32], exp[31:0]);
    end
    out_ready32 = 1'b1;
    tick();
    out_ready32 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ready=%b valid=%b want 1/0", in_ready8, out_valid8);
    end
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++; $display("FAIL reset_result: got sum=%h cout=%b want 00/0", sum8, cout8);
    end
    checks++;
    if (in_ready1 !== 1'b1 || in_ready32 !== 1'b1 || out_valid1 !== 1'b0 || out_valid32 !== 1'b0) begin
      errors++; $display("FAIL reset_params: got ready1=%b ready32=%b valid1=%b valid32=%b want 1/1/0/0",
                         in_ready1, in_ready32, out_valid1, out_valid32);
    end
  endtask

  task automatic test_basic();
    run8(8'h5A, 8'h3C, "basic");
  endtask

  task automatic test_carry_chain();
    run8(8'hFF, 8'h01, "carry_ff_01");
    run8(8'hFF, 8'hFF, "carry_ff_ff");
    run8(8'h00, 8'h00, "carry_zero");
  endtask

  task automatic test_backpressure();
    logic [8:0] exp;
    int lat;
    exp = 9'h077 + 9'h099;
    a8 = 8'h77; b8 = 8'h99; in_valid8 = 1'b1;
    tick();
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 64) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick(); lat++;
    end
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL bp_latency: got %0d want 8", lat);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || {cout8, sum8} !== exp) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b ready=%b cout=%b sum=%h want 1/0/%b/%h",
                           i, out_valid8, in_ready8, cout8, sum8, exp[8], exp[7:0]);
      end
      if (i < 5) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        tick();
      end
    end
    out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    a8 = 8'h12; b8 = 8'h34; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++; $display("FAIL midrst_state: got ready=%b valid=%b sum=%h cout=%b want 1/0/00/0",
                         in_ready8, out_valid8, sum8, cout8);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid8 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen);
    end
    run8(8'h01, 8'h01, "midrst_after");
  endtask

  task automatic test_back_to_back();
    logic [8:0] sb[$];
    logic [8:0] exp;
    logic [7:0] d, s;
    int last_acc, w;
    last_acc = -1;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      w = 0;
      while (in_ready8 !== 1'b1 && w < 64) begin tick(); w++; end
      d = 8'($urandom); s = 8'($urandom);
      a8 = d; b8 = s;
      sb.push_back({1'b0, d} + {1'b0, s});
      tick();
      if (last_acc >= 0) begin
        checks++;
        if (cyc - last_acc !== 10) begin
          errors++; $display("FAIL b2b_interval[%0d]: got %0d want 10", i, cyc - last_acc);
        end
      end
      last_acc = cyc;
      w = 0;
      while (out_valid8 !== 1'b1 && w < 64) begin tick(); w++; end
      exp = sb.pop_front();
      checks++;
      if ({cout8, sum8} !== exp) begin
        errors++; $display("FAIL b2b_result[%0d]: %h+%h got cout=%b sum=%h want cout=%b sum=%h",
                           i, d, s, cout8, sum8, exp[8], exp[7:0]);
      end
    end
    in_valid8 = 1'b0;
    tick();
    out_ready8 = 1'b0;
  endtask

  task automatic test_width1();
    run1(1'b1, 1'b1, "w1_1p1");
    run1(1'b0, 1'b1, "w1_0p1");
  endtask

  task automatic test_width32();
    run32(32'hFFFF_FFFF, 32'h0000_0001, "w32_wrap");
    run32($urandom, $urandom, "w32_rand");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_width1();
    test_width32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
